// File: rtl/bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bus_arbiter_pkg
//   Shared constants and types for the system memory bus arbiter.
//   - MEM_ADDR_BUS / MEM_DATA_BUS : default bus widths
//   - HOLD_FLAG_BUS               : width of the stall request into ctrl
//   - MST_*                       : master index assignments
//   - bus_state_e                 : arbiter FSM state encoding
//   - idx_width()                 : width of a winner index for n masters
//   Optional feature macro: BUS_TIMEOUT_EN (used by bus_arbiter).
// ---------------------------------------------------------------------------
package bus_arbiter_pkg;

  localparam int MEM_ADDR_BUS  = 32;
  localparam int MEM_DATA_BUS  = 32;
  localparam int HOLD_FLAG_BUS = 1;

  // Master index map; lower index means higher priority.
  localparam int MST_DBG  = 0;  // debug / JTAG
  localparam int MST_EX   = 1;  // EX stage load/store
  localparam int MST_IF   = 2;  // IF stage fetch
  localparam int MST_UART = 3;  // UART loader

  // Watchdog counter width.
  localparam int TMO_W = 8;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_BUSY = 1'b1
  } bus_state_e;

  // A single master still needs a 1-bit index so vectors never collapse to [-1:0].
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_prio_enc.sv
// ---------------------------------------------------------------------------
// bus_arbiter_prio_enc
//   Fixed-priority encoder: the lowest set bit of the request vector wins.
//   Ports:
//     req_i   [NM-1:0]  request vector
//     valid_o           at least one request present
//     idx_o   [IW-1:0]  index of the winning request (0 when none)
// ---------------------------------------------------------------------------
module bus_arbiter_prio_enc #(
  parameter int NM = 4,
  parameter int IW = 2
) (
  input  logic [NM-1:0] req_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    // Scan from the top down so the last hit, the lowest index, sticks.
    for (int k = NM - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        idx_o = IW'(k);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//   Shares the single system memory bus between NM masters with fixed
//   priority (lowest index wins) and one transaction in flight.
//
//   Handshake (both sides): a requester raises req and holds it, with stable
//   fields, until it sees a one-cycle ack. The arbiter samples m_req_i only
//   in IDLE; in BUSY it drives s_req_o with the latched fields until s_ack_i.
//   s_ack_i is returned to the owner in the same cycle as m_ack_o[grant],
//   with m_rdata_o = s_rdata_i; m_rdata_o is 0 in every other cycle.
//
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     m_req_i/m_we_i    per-master request and write enable
//     m_addr_i          per-master address, master k at [k*AW +: AW]
//     m_wdata_i         per-master write data, master k at [k*DW +: DW]
//     m_rdata_o         read data to the owner, qualified by m_ack_o
//     m_ack_o           one-cycle completion pulse to the owner
//     m_err_o           error qualifier for m_ack_o (watchdog expiry)
//     s_req_o/s_we_o    downstream request / write enable
//     s_addr_o/s_wdata_o downstream address / write data
//     s_rdata_i/s_ack_i downstream read data / completion pulse
//     bus_hold_flag_o   stall request to ctrl for masters in HOLD_MASK
//     dbg_state_o       current arbiter FSM state
//
//   Optional feature: define BUS_TIMEOUT_EN to add a watchdog that completes
//   a stalled access with m_err_o after TMO_CYC cycles in BUSY. Without it
//   m_err_o is never raised and BUSY waits for s_ack_i indefinitely.
// ---------------------------------------------------------------------------
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int              NM        = 4,
  parameter int              AW        = MEM_ADDR_BUS,
  parameter int              DW        = MEM_DATA_BUS,
  parameter logic [NM-1:0]   HOLD_MASK = NM'(4'b0110),
  parameter int              TMO_CYC   = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NM-1:0]            m_req_i,
  input  logic [NM-1:0]            m_we_i,
  input  logic [NM*AW-1:0]         m_addr_i,
  input  logic [NM*DW-1:0]         m_wdata_i,
  output logic [DW-1:0]            m_rdata_o,
  output logic [NM-1:0]            m_ack_o,
  output logic                     m_err_o,
  output logic                     s_req_o,
  output logic                     s_we_o,
  output logic [AW-1:0]            s_addr_o,
  output logic [DW-1:0]            s_wdata_o,
  input  logic [DW-1:0]            s_rdata_i,
  input  logic                     s_ack_i,
  output logic [HOLD_FLAG_BUS-1:0] bus_hold_flag_o,
  output bus_state_e               dbg_state_o
);

  localparam int IW = idx_width(NM);

  // Configuration sanity checks, evaluated at elaboration only.
  if (NM < 1 || NM > 8) begin : g_bad_nm
    $error("bus_arbiter: NM must be in 1..8");
  end
  if (TMO_CYC < 1 || TMO_CYC > 255) begin : g_bad_tmo
    $error("bus_arbiter: TMO_CYC must be in 1..255");
  end

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  bus_state_e    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic          we_q,    we_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  // ---------------------------------------------------------------------
  // Arbitration: winner index and its request fields
  // ---------------------------------------------------------------------
  logic          win_valid;
  logic [IW-1:0] win_idx;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  bus_arbiter_prio_enc #(
    .NM (NM),
    .IW (IW)
  ) u_prio_enc (
    .req_i   (m_req_i),
    .valid_o (win_valid),
    .idx_o   (win_idx)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < NM; k++) begin
      if (win_idx == IW'(k)) begin
        sel_we    = m_we_i[k];
        sel_addr  = m_addr_i[k*AW +: AW];
        sel_wdata = m_wdata_i[k*DW +: DW];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Completion: a slave ack, or (optionally) the watchdog firing
  // ---------------------------------------------------------------------
  logic tmo_hit;
  logic done;

  assign done = (state_q == BUS_BUSY) && (s_ack_i || tmo_hit);

`ifdef BUS_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TMO_CYC);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Counter is 0 in the first BUSY cycle, so expiry lands TMO_CYC cycles in.
  // A slave ack in the expiry cycle takes precedence over the error.
  assign tmo_hit = (state_q == BUS_BUSY) && !s_ack_i && (tmo_cnt_q == TMO_LIMIT);

  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == BUS_BUSY && !done) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BUS_IDLE;
      grant_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state and outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    s_req_o   = 1'b0;
    m_ack_o   = '0;
    m_rdata_o = '0;
    m_err_o   = 1'b0;

    unique case (state_q)
      BUS_IDLE: begin
        // s_ack_i is deliberately ignored here.
        if (win_valid) begin
          state_d = BUS_BUSY;
          grant_d = win_idx;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
        end
      end

      BUS_BUSY: begin
        // Requests are not re-sampled; a withdrawn request still completes.
        s_req_o = 1'b1;
        if (done) begin
          state_d = BUS_IDLE;
          for (int k = 0; k < NM; k++) begin
            m_ack_o[k] = (grant_q == IW'(k));
          end
          if (s_ack_i) begin
            m_rdata_o = s_rdata_i;
          end else begin
            m_err_o = 1'b1;
          end
        end
      end

      default: begin
        state_d = BUS_IDLE;
      end
    endcase
  end

  // Latched fields stay on the downstream bus, stable for the whole access.
  assign s_we_o    = we_q;
  assign s_addr_o  = addr_q;
  assign s_wdata_o = wdata_q;

  // Stall ctrl while a core master waits or is being served, but not in its
  // own ack cycle, so the pipeline can advance on the ack edge. Forced low
  // during reset regardless of what the masters present.
  assign bus_hold_flag_o = rst_n & (|(m_req_i & HOLD_MASK & ~m_ack_o));

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
`timescale 1ns/1ps
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int EW = NM + 1 + DW;  // {ack, err, rdata}
  localparam int SW = 1 + AW + DW;  // {we, addr, wdata}

  // ---------------- clock / reset / DUT ----------------
  logic              clk;
  logic              rst_n;
  logic [NM-1:0]     m_req_i;
  logic [NM-1:0]     m_we_i;
  logic [NM*AW-1:0]  m_addr_i;
  logic [NM*DW-1:0]  m_wdata_i;
  logic [DW-1:0]     m_rdata_o;
  logic [NM-1:0]     m_ack_o;
  logic              m_err_o;
  logic              s_req_o;
  logic              s_we_o;
  logic [AW-1:0]     s_addr_o;
  logic [DW-1:0]     s_wdata_o;
  logic [DW-1:0]     s_rdata_i;
  logic              s_ack_i;
  logic [0:0]        bus_hold_flag_o;
  bus_state_e        dbg_state_o;

  logic              slv_ack;
  assign s_ack_i = slv_ack;

  bus_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .m_req_i         (m_req_i),
    .m_we_i          (m_we_i),
    .m_addr_i        (m_addr_i),
    .m_wdata_i       (m_wdata_i),
    .m_rdata_o       (m_rdata_o),
    .m_ack_o         (m_ack_o),
    .m_err_o         (m_err_o),
    .s_req_o         (s_req_o),
    .s_we_o          (s_we_o),
    .s_addr_o        (s_addr_o),
    .s_wdata_o       (s_wdata_o),
    .s_rdata_i       (s_rdata_i),
    .s_ack_i         (s_ack_i),
    .bus_hold_flag_o (bus_hold_flag_o),
    .dbg_state_o     (dbg_state_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];
  logic [SW-1:0] exp_s_q[$];

  int slave_lat     = 1;
  bit slave_en      = 1'b1;
  int spur_cnt      = 0;
  bit hold_zero_chk = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] slave_lookup(input logic [AW-1:0] a);
    case (a)
      32'h0000_1000: return 32'hDEAD_BEEF;
      32'h0000_2000: return 32'h0BAD_F00D;
      32'h0000_3000: return 32'h1357_9BDF;
      32'h0000_4000: return 32'h2468_ACE0;
      32'h0000_5000: return 32'h89AB_CDEF;
      default:       return 32'hFFFF_0000;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int k, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_we_i[k]               = we;
    m_addr_i[k*AW +: AW]    = a;
    m_wdata_i[k*DW +: DW]   = d;
    m_req_i[k]              = 1'b1;
    exp_s_q.push_back({we, a, d});
  endtask

  task automatic push_ack(input logic [NM-1:0] ack, input logic err, input logic [DW-1:0] rd);
    exp_q.push_back({ack, err, rd});
  endtask

  // Wait for master k's ack, then drop its request right after the ack edge.
  task automatic wait_ack(input int k, input int budget, output int at, output logic hold_at);
    bit seen = 1'b0;
    at      = -1;
    hold_at = 1'bx;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (m_ack_o[k]) begin
        seen    = 1'b1;
        at      = cyc;
        hold_at = bus_hold_flag_o[0];
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL ack_timeout_m%0d got=none want=ack within %0d cycles", k, budget);
    end
    tick();
    m_req_i[k] = 1'b0;
  endtask

  // ---------------- slave model + downstream checker ----------------
  initial begin
    logic [SW-1:0] cur;
    bit            in_txn;
    int            wait_cnt;
    int            spur_done;
    slv_ack   = 1'b0;
    s_rdata_i = '0;
    in_txn    = 1'b0;
    wait_cnt  = 0;
    spur_done = 0;
    cur       = '0;
    forever begin
      tick();
      if (slv_ack) begin
        slv_ack   = 1'b0;
        s_rdata_i = '0;
        in_txn    = 1'b0;
        wait_cnt  = 0;
      end else if (spur_cnt != spur_done && !s_req_o) begin
        spur_done++;
        slv_ack   = 1'b1;
        s_rdata_i = 32'hCAFE_F00D;
      end else if (s_req_o) begin
        if (!in_txn) begin
          in_txn = 1'b1;
          total++;
          if (exp_s_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_s_req got=%0h want=none", {s_we_o, s_addr_o, s_wdata_o});
            cur = {s_we_o, s_addr_o, s_wdata_o};
          end else begin
            cur = exp_s_q.pop_front();
            if ({s_we_o, s_addr_o, s_wdata_o} !== cur) begin
              bad++;
              $display("FAIL s_fields got=%0h want=%0h", {s_we_o, s_addr_o, s_wdata_o}, cur);
            end
          end
        end else begin
          chk("s_fields_stable", 64'({s_we_o, s_addr_o}), 64'(cur[SW-1 -: 1+AW]));
        end
        if (slave_en && wait_cnt >= slave_lat) begin
          slv_ack   = 1'b1;
          s_rdata_i = slave_lookup(s_addr_o);
        end else begin
          wait_cnt++;
          // Junk on the data lines while stalling; must never reach a master.
          s_rdata_i = 32'h5A5A_0000 ^ DW'(wait_cnt);
        end
      end else begin
        in_txn    = 1'b0;
        wait_cnt  = 0;
        s_rdata_i = '0;
      end
    end
  end

  // ---------------- monitor ----------------
  initial forever begin
    logic [EW-1:0] e;
    @(negedge clk);
    if (m_ack_o != '0) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ack got=%b want=none", m_ack_o);
      end else begin
        e = exp_q.pop_front();
        if ({m_ack_o, m_err_o, m_rdata_o} !== e) begin
          bad++;
          $display("FAIL ack_resp got=%0h want=%0h", {m_ack_o, m_err_o, m_rdata_o}, e);
        end
      end
    end else begin
      chk("idle_rdata_err", 64'({m_err_o, m_rdata_o}), 64'd0);
    end
    if (hold_zero_chk) begin
      chk("hold_low_nonmask", 64'(bus_hold_flag_o), 64'd0);
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int   c0, at, at1, at2;
    logic h;
    bit   seen;

    rst_n     = 1'b0;
    m_we_i    = '0;
    m_addr_i  = '0;
    m_wdata_i = '0;
    m_req_i   = 4'b0110;  // core requests present during reset
    repeat (2) @(negedge clk);
    chk("rst_s_req", 64'(s_req_o), 64'd0);
    chk("rst_ack", 64'(m_ack_o), 64'd0);
    chk("rst_err", 64'(m_err_o), 64'd0);
    chk("rst_rdata", 64'(m_rdata_o), 64'd0);
    chk("rst_hold", 64'(bus_hold_flag_o), 64'd0);
    chk("rst_state", 64'(dbg_state_o), 64'(BUS_IDLE));
    tick();
    m_req_i = '0;
    rst_n   = 1'b1;
    tick();

    // 1: single M2 read, slave acks one cycle after s_req_o
    slave_lat = 1;
    tick();
    c0 = cyc;
    issue(MST_IF, 1'b0, 32'h0000_1000, 32'h0);
    push_ack(4'b0100, 1'b0, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t1_idle_hold", 64'(bus_hold_flag_o), 64'd1);
    chk("t1_idle_sreq", 64'(s_req_o), 64'd0);
    @(negedge clk);
    chk("t1_busy_sreq", 64'(s_req_o), 64'd1);
    chk("t1_busy_addr", 64'(s_addr_o), 64'h1000);
    chk("t1_busy_hold", 64'(bus_hold_flag_o), 64'd1);
    wait_ack(MST_IF, 10, at, h);
    chk("t1_ack_hold", 64'(h), 64'd0);
    chk("t1_ack_cycle", 64'(at - c0), 64'd2);

    // 2: M1 and M2 together, M1 first, M2 after one IDLE cycle
    slave_lat = 0;
    tick();
    c0 = cyc;
    issue(MST_EX, 1'b1, 32'h0000_2000, 32'h1111_2222);
    issue(MST_IF, 1'b0, 32'h0000_3000, 32'h0);
    push_ack(4'b0010, 1'b0, 32'h0BAD_F00D);
    push_ack(4'b0100, 1'b0, 32'h1357_9BDF);
    wait_ack(MST_EX, 10, at1, h);
    chk("t2_hold_m2_pending", 64'(h), 64'd1);
    wait_ack(MST_IF, 10, at2, h);
    chk("t2_first_lat", 64'(at1 - c0), 64'd1);
    chk("t2_gap", 64'(at2 - at1), 64'd2);

    // 3: M3 stalled 10 cycles, M0 arrives meanwhile; hold stays low
    slave_lat     = 10;
    hold_zero_chk = 1'b1;
    tick();
    c0 = cyc;
    issue(MST_UART, 1'b0, 32'h0000_4000, 32'h0);
    push_ack(4'b1000, 1'b0, 32'h2468_ACE0);
    repeat (3) @(negedge clk);
    chk("t3_state_busy", 64'(dbg_state_o), 64'(BUS_BUSY));
    tick();
    issue(MST_DBG, 1'b1, 32'h0000_5000, 32'hFEED_C0DE);
    push_ack(4'b0001, 1'b0, 32'h89AB_CDEF);
    wait_ack(MST_UART, 40, at1, h);
    wait_ack(MST_DBG, 40, at2, h);
    hold_zero_chk = 1'b0;
    chk("t3_m3_lat", 64'(at1 - c0), 64'd11);
    chk("t3_m0_after", 64'(at2 - at1), 64'd12);

    // 4: reset during BUSY abandons the access
    slave_lat = 20;
    tick();
    issue(MST_EX, 1'b0, 32'h0000_6000, 32'h0);
    repeat (3) @(negedge clk);
    chk("t4_busy_sreq", 64'(s_req_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_sreq", 64'(s_req_o), 64'd0);
    chk("t4_rst_ack", 64'(m_ack_o), 64'd0);
    chk("t4_rst_hold", 64'(bus_hold_flag_o), 64'd0);
    tick();
    m_req_i[MST_EX] = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t4_post_state", 64'(dbg_state_o), 64'(BUS_IDLE));
    chk("t4_post_sreq", 64'(s_req_o), 64'd0);
    slave_lat = 1;
    tick();
    c0 = cyc;
    issue(MST_IF, 1'b0, 32'h0000_1000, 32'h0);
    push_ack(4'b0100, 1'b0, 32'hDEAD_BEEF);
    wait_ack(MST_IF, 10, at, h);
    chk("t4_fresh_cycle", 64'(at - c0), 64'd2);

    // 5: slave never acks
    slave_en = 1'b0;
`ifdef BUS_TIMEOUT_EN
    tick();
    c0 = cyc;
    issue(MST_IF, 1'b0, 32'h0000_7000, 32'h0);
    push_ack(4'b0100, 1'b1, 32'h0);
    wait_ack(MST_IF, 300, at, h);
    chk("t5_tmo_cycle", 64'(at - c0), 64'd256);
    @(negedge clk);
    chk("t5_sreq_dropped", 64'(s_req_o), 64'd0);
`else
    tick();
    issue(MST_IF, 1'b0, 32'h0000_7000, 32'h0);
    seen = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (m_ack_o != '0) seen = 1'b1;
    end
    chk("t5_no_ack", 64'(seen), 64'd0);
    chk("t5_still_busy", 64'(s_req_o), 64'd1);
    tick();
    rst_n = 1'b0;
    m_req_i[MST_IF] = 1'b0;
    tick();
    rst_n = 1'b1;
`endif
    slave_en = 1'b1;

    // 6: spurious s_ack_i while IDLE
    tick();
    spur_cnt++;
    repeat (3) begin
      @(negedge clk);
      chk("t6_no_ack", 64'(m_ack_o), 64'd0);
      chk("t6_state_idle", 64'(dbg_state_o), 64'(BUS_IDLE));
    end
    slave_lat = 2;
    tick();
    c0 = cyc;
    issue(MST_EX, 1'b1, 32'h0000_2000, 32'hA5A5_5A5A);
    push_ack(4'b0010, 1'b0, 32'h0BAD_F00D);
    wait_ack(MST_EX, 10, at, h);
    chk("t6_after_cycle", 64'(at - c0), 64'd3);

    repeat (3) @(negedge clk);
    chk("end_ack_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("end_sreq_queue_empty", 64'(exp_s_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
